// File: rtl/fpga_pkg.sv
// Shared types and sizing helpers for the fpga-side program I/O blocks.
package fpga_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned MEM_ELEM_W = 12;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned POS_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ring_buffer.sv
// Circular word store with push/pop ports; pop must only be issued when not empty.
module ring_buffer
  import fpga_pkg::*;
#(
  parameter int unsigned W     = MEM_ELEM_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [W-1:0]                   wdata_i,
  input  logic                           pop_i,
  output logic [W-1:0]                   rdata_o,
  output logic [POS_W(DEPTH+1)-1:0]      count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned PW = POS_W(DEPTH);
  localparam int unsigned CW = POS_W(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_pos_q, wr_pos_d;
  logic [PW-1:0] rd_pos_q, rd_pos_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] inc_pos(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_pos_d = wr_pos_q;
    rd_pos_d = rd_pos_q;
    count_d  = count_q;
    if (push_i) wr_pos_d = inc_pos(wr_pos_q);
    if (pop_i)  rd_pos_d = inc_pos(rd_pos_q);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_pos_q <= '0;
      rd_pos_q <= '0;
      count_q  <= '0;
    end else begin
      wr_pos_q <= wr_pos_d;
      rd_pos_q <= rd_pos_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are only observed once counted in.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_pos_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_pos_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/out_channel_reader.sv
// Buffers program `out` words and streams them on valid/ready; tracks program completion.
module out_channel_reader
  import fpga_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = MEM_ELEM_W,
  parameter int unsigned NOut               = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            outWrite,
  input  logic [MemoryElementWidth-1:0]   outData,
  input  logic                            finished,
  output logic                            valid,
  output logic [MemoryElementWidth-1:0]   data,
  input  logic                            ready,
  output logic [POS_W(NOut+1)-1:0]        count,
  output logic                            overflow,
  output logic                            drained
);

  localparam int unsigned CW = POS_W(NOut + 1);

  state_e        state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          rd_c, wr_acc_c;
  logic          full_c, empty_c;
  logic [CW-1:0] count_c;

  ring_buffer #(
    .W     (MemoryElementWidth),
    .DEPTH (NOut)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .push_i  (wr_acc_c),
    .wdata_i (outData),
    .pop_i   (rd_c),
    .rdata_o (data),
    .count_o (count_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  // A full buffer still accepts a write when the head leaves in the same cycle.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    rd_c       = !empty_c && ready;
    wr_acc_c   = outWrite && (state_q == RUN) && (!full_c || rd_c);
    if (outWrite && !wr_acc_c) overflow_d = 1'b1;
    unique case (state_q)
      RUN:     if (finished) state_d = DRAIN;
      DRAIN:   if (empty_c || (count_c == CW'(1) && rd_c)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = !empty_c;
  assign count    = count_c;
  assign overflow = overflow_q;
  assign drained  = (state_q == DONE);

endmodule
